// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scancode decoder: protocol byte
// constants and the pop-handshake state encoding.
`timescale 1ns/1ps
package ps2_pkg;

  // Set-2 protocol bytes
  localparam logic [7:0] SC_EXT  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK  = 8'hF0;  // break (release) prefix
  localparam logic [7:0] SC_ERR0 = 8'h00;  // keyboard buffer error / overrun
  localparam logic [7:0] SC_ERR1 = 8'hFF;  // keyboard internal error

  // Pop handshake: fetch a byte, hold the pop strobe one cycle, settle one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // True for the two error bytes a keyboard can emit in place of a scancode
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational Set-2 scancode to ASCII lookup. Letters give lowercase,
// digits and space map directly, Enter gives CR; anything else gives 0x00.
`timescale 1ns/1ps
module scancode_to_ascii (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  // Lookup table
  always_comb begin
    ascii_o = '0;
    unique case (code_i)
      8'h1C: ascii_o = 8'h61; // a
      8'h32: ascii_o = 8'h62; // b
      8'h21: ascii_o = 8'h63; // c
      8'h23: ascii_o = 8'h64; // d
      8'h24: ascii_o = 8'h65; // e
      8'h2B: ascii_o = 8'h66; // f
      8'h34: ascii_o = 8'h67; // g
      8'h33: ascii_o = 8'h68; // h
      8'h43: ascii_o = 8'h69; // i
      8'h3B: ascii_o = 8'h6A; // j
      8'h42: ascii_o = 8'h6B; // k
      8'h4B: ascii_o = 8'h6C; // l
      8'h3A: ascii_o = 8'h6D; // m
      8'h31: ascii_o = 8'h6E; // n
      8'h44: ascii_o = 8'h6F; // o
      8'h4D: ascii_o = 8'h70; // p
      8'h15: ascii_o = 8'h71; // q
      8'h2D: ascii_o = 8'h72; // r
      8'h1B: ascii_o = 8'h73; // s
      8'h2C: ascii_o = 8'h74; // t
      8'h3C: ascii_o = 8'h75; // u
      8'h2A: ascii_o = 8'h76; // v
      8'h1D: ascii_o = 8'h77; // w
      8'h22: ascii_o = 8'h78; // x
      8'h35: ascii_o = 8'h79; // y
      8'h1A: ascii_o = 8'h7A; // z
      8'h45: ascii_o = 8'h30; // 0
      8'h16: ascii_o = 8'h31; // 1
      8'h1E: ascii_o = 8'h32; // 2
      8'h26: ascii_o = 8'h33; // 3
      8'h25: ascii_o = 8'h34; // 4
      8'h2E: ascii_o = 8'h35; // 5
      8'h36: ascii_o = 8'h36; // 6
      8'h3D: ascii_o = 8'h37; // 7
      8'h3E: ascii_o = 8'h38; // 8
      8'h46: ascii_o = 8'h39; // 9
      8'h29: ascii_o = 8'h20; // space
      8'h5A: ascii_o = 8'h0D; // enter
      default: ascii_o = '0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops bytes from the PS/2 receive FIFO, parses Set-2 make/break/extended
// sequences, tracks the held key with its ASCII value, counts presses and
// emits single-cycle make/break pulses.
`timescale 1ns/1ps
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter bit          IGNORE_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic             make_pulse,
  output logic             break_pulse,
  output logic [CNT_W-1:0] press_count,
  output logic             err_sticky
);

  state_t             state_q;
  logic [7:0]         byte_q;
  logic               nextdata_n_q;
  logic               ext_pend_q,  ext_pend_d;
  logic               brk_pend_q,  brk_pend_d;
  logic [7:0]         key_code_q,  key_code_d;
  logic               key_ext_q,   key_ext_d;
  logic [7:0]         key_ascii_q, key_ascii_d;
  logic               key_held_q,  key_held_d;
  logic               make_q,      make_d;
  logic               break_q,     break_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               err_q;
  logic [7:0]         rom_ascii;
  logic               same_key;

  scancode_to_ascii u_rom (
    .code_i  (byte_q),
    .ascii_o (rom_ascii)
  );

  // Parse the latched byte against the pending prefixes and the held key
  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_ascii_d = key_ascii_q;
    key_held_d  = key_held_q;
    make_d      = 1'b0;
    break_d     = 1'b0;
    count_d     = count_q;
    same_key    = key_held_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

    if (byte_q == SC_EXT) begin
      ext_pend_d = 1'b1;
    end else if (byte_q == SC_BRK) begin
      brk_pend_d = 1'b1;
    end else if (is_err_byte(byte_q)) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (brk_pend_q) begin
      // Release of a key other than the held one leaves outputs untouched
      if (same_key) begin
        key_held_d = 1'b0;
        break_d    = 1'b1;
      end
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else begin
      if (!(same_key && IGNORE_REPEAT)) begin
        key_code_d  = byte_q;
        key_ext_d   = ext_pend_q;
        key_ascii_d = ext_pend_q ? 8'h00 : rom_ascii;
        key_held_d  = 1'b1;
        make_d      = 1'b1;
        count_d     = count_q + CNT_W'(1);
      end
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  // Pop handshake FSM; all decoded outputs commit on the edge closing S_POP
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      byte_q       <= '0;
      nextdata_n_q <= 1'b1;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_ascii_q  <= '0;
      key_held_q   <= 1'b0;
      make_q       <= 1'b0;
      break_q      <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      make_q  <= 1'b0;
      break_q <= 1'b0;
      if (fifo_overflow) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (fifo_ready) begin
            byte_q       <= fifo_data;
            nextdata_n_q <= 1'b0;
            state_q      <= S_POP;
          end
        end
        S_POP: begin
          nextdata_n_q <= 1'b1;
          ext_pend_q   <= ext_pend_d;
          brk_pend_q   <= brk_pend_d;
          key_code_q   <= key_code_d;
          key_ext_q    <= key_ext_d;
          key_ascii_q  <= key_ascii_d;
          key_held_q   <= key_held_d;
          make_q       <= make_d;
          break_q      <= break_d;
          count_q      <= count_d;
          state_q      <= S_GAP;
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          nextdata_n_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_ascii   = key_ascii_q;
  assign key_held    = key_held_q;
  assign make_pulse  = make_q;
  assign break_pulse = break_q;
  assign press_count = count_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a queue-based FIFO model feeds two
// instances (repeat filtering on and off) and a byte-level reference
// model checks every output on every cycle.
`timescale 1ns/1ps
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;

  logic       nextdata_n, key_ext, key_held, make_pulse, break_pulse, err_sticky;
  logic [7:0] key_code, key_ascii, press_count;
  logic       nextdata_n_nr, key_ext_nr, key_held_nr, make_pulse_nr, break_pulse_nr, err_sticky_nr;
  logic [7:0] key_code_nr, key_ascii_nr, press_count_nr;

  ps2_scancode_decoder #(.CNT_W(8), .IGNORE_REPEAT(1'b1)) dut (
    .clk(clk), .clrn(clrn), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .fifo_overflow(fifo_overflow), .nextdata_n(nextdata_n), .key_code(key_code),
    .key_ext(key_ext), .key_ascii(key_ascii), .key_held(key_held),
    .make_pulse(make_pulse), .break_pulse(break_pulse), .press_count(press_count),
    .err_sticky(err_sticky)
  );

  ps2_scancode_decoder #(.CNT_W(8), .IGNORE_REPEAT(1'b0)) dut_nr (
    .clk(clk), .clrn(clrn), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .fifo_overflow(fifo_overflow), .nextdata_n(nextdata_n_nr), .key_code(key_code_nr),
    .key_ext(key_ext_nr), .key_ascii(key_ascii_nr), .key_held(key_held_nr),
    .make_pulse(make_pulse_nr), .break_pulse(break_pulse_nr), .press_count(press_count_nr),
    .err_sticky(err_sticky_nr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] let_codes [26];
  logic [7:0] dig_codes [10];
  logic [7:0] q [$];

  logic [7:0] m_code, m_ascii, m_cnt, m_cnt_nr;
  logic       m_ext, m_held, m_err, ext_p, brk_p;
  logic       due_mk, due_bk, due_mk_nr;
  int         lo_run, hi_run;
  bit         seen_pop;
  int         n_mk, n_bk;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (let_codes[i] == c) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    bit same;
    same = m_held && (b == m_code) && (ext_p == m_ext);
    if (b == 8'hE0) ext_p = 1'b1;
    else if (b == 8'hF0) brk_p = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin ext_p = 1'b0; brk_p = 1'b0; end
    else if (brk_p) begin
      if (same) begin m_held = 1'b0; due_bk = 1'b1; end
      ext_p = 1'b0; brk_p = 1'b0;
    end else begin
      // repeat-filtered instance
      if (!same) begin
        m_code = b; m_ext = ext_p; m_ascii = ext_p ? 8'h00 : ref_ascii(b);
        m_held = 1'b1; due_mk = 1'b1; m_cnt = m_cnt + 8'd1;
      end
      // unfiltered instance: every make counts (its key state is identical)
      due_mk_nr = 1'b1; m_cnt_nr = m_cnt_nr + 8'd1;
      ext_p = 1'b0; brk_p = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_code = 0; m_ascii = 0; m_cnt = 0; m_cnt_nr = 0;
    m_ext = 0; m_held = 0; m_err = 0; ext_p = 0; brk_p = 0;
    due_mk = 0; due_bk = 0; due_mk_nr = 0;
    lo_run = 0; hi_run = 0; seen_pop = 0;
    q.delete();
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_ready = 1'b1;
    fifo_data  = q[0];
  endtask

  // One cycle: compare outputs at the falling edge, then service the FIFO pop
  task automatic tick();
    @(negedge clk);
    if (clrn !== 1'b1) return;
    chk("key_code",    key_code,    m_code);
    chk("key_ext",     key_ext,     m_ext);
    chk("key_ascii",   key_ascii,   m_ascii);
    chk("key_held",    key_held,    m_held);
    chk("make_pulse",  make_pulse,  due_mk);
    chk("break_pulse", break_pulse, due_bk);
    chk("press_count", press_count, m_cnt);
    chk("err_sticky",  err_sticky,  m_err);
    chk("nr_count",    press_count_nr, m_cnt_nr);
    chk("nr_make",     make_pulse_nr,  due_mk_nr);
    chk("nr_break",    break_pulse_nr, due_bk);
    chk("nr_nextdata", nextdata_n_nr,  nextdata_n);
    if (make_pulse)  n_mk++;
    if (break_pulse) n_bk++;
    due_mk = 0; due_bk = 0; due_mk_nr = 0;
    if (nextdata_n == 1'b0) begin
      chk("pop_width", lo_run, 0);
      if (seen_pop) chk("pop_gap", 32'(hi_run >= 2), 1);
      chk("pop_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        model_byte(q[0]);
        void'(q.pop_front());
      end
      lo_run++; hi_run = 0; seen_pop = 1;
    end else begin
      lo_run = 0; hi_run++;
    end
    fifo_ready = (q.size() != 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (q.size() != 0 && i < budget) begin tick(); i++; end
    if (q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL idle_timeout: %0d bytes left, required 0", q.size());
      q.delete();
    end
    repeat (4) tick();
  endtask

  // Assert reset between clock edges and check outputs clear immediately
  task automatic reset_async();
    @(posedge clk); #3;
    clrn = 1'b0;
    #1;
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_code",   key_code,   0);
    chk("rst_key_ext",    key_ext,    0);
    chk("rst_key_ascii",  key_ascii,  0);
    chk("rst_key_held",   key_held,   0);
    chk("rst_make",       make_pulse, 0);
    chk("rst_break",      break_pulse, 0);
    chk("rst_count",      press_count, 0);
    chk("rst_err",        err_sticky, 0);
    chk("rst_nr_count",   press_count_nr, 0);
    model_reset();
    fifo_ready = 0; fifo_data = 0; fifo_overflow = 0;
    @(negedge clk); @(negedge clk);
    clrn = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [39:0] bytes;   // first byte in the MSBs
    int          n;
    logic [7:0]  code;
    logic        ext;
    logic [7:0]  ascii;
    logic        held;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nr;
    int          mk;
    int          bk;
  } vec_t;

  vec_t        vecs [11];
  logic [39:0] tbytes;
  logic [7:0]  pool [8];

  initial begin
    let_codes = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                  8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    dig_codes = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    pool      = '{8'h1C,8'h32,8'h16,8'h29,8'h5A,8'h75,8'h66,8'h45};

    vecs[0]  = '{40'h1CF01C0000, 3, 8'h1C, 1'b0, 8'h61, 1'b0, 8'd1, 8'd1, 1, 1};
    vecs[1]  = '{40'h1C1C1CF01C, 5, 8'h1C, 1'b0, 8'h61, 1'b0, 8'd1, 8'd3, 1, 1};
    vecs[2]  = '{40'hE075E0F075, 5, 8'h75, 1'b1, 8'h00, 1'b0, 8'd1, 8'd1, 1, 1};
    vecs[3]  = '{40'hE075F07500, 4, 8'h75, 1'b1, 8'h00, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[4]  = '{40'h1629F01600, 4, 8'h29, 1'b0, 8'h20, 1'b1, 8'd2, 8'd2, 2, 0};
    vecs[5]  = '{40'h5A00000000, 1, 8'h5A, 1'b0, 8'h0D, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[6]  = '{40'hF0FF1C0000, 3, 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[7]  = '{40'hE0001C0000, 3, 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[8]  = '{40'h1CF0E01C00, 4, 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[9]  = '{40'h1500000000, 1, 8'h15, 1'b0, 8'h71, 1'b1, 8'd1, 8'd1, 1, 0};
    vecs[10] = '{40'h1C32F01C00, 4, 8'h32, 1'b0, 8'h62, 1'b1, 8'd2, 8'd2, 2, 0};

    clrn = 1'b0; fifo_ready = 0; fifo_data = 0; fifo_overflow = 0;
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    for (int r = 0; r < 11; r++) begin
      reset_async();
      n_mk = 0; n_bk = 0;
      tbytes = vecs[r].bytes;
      for (int k = 0; k < vecs[r].n; k++) push(tbytes[39-8*k -: 8]);
      wait_idle(100);
      chk($sformatf("row%0d_code", r),   key_code,       vecs[r].code);
      chk($sformatf("row%0d_ext", r),    key_ext,        vecs[r].ext);
      chk($sformatf("row%0d_ascii", r),  key_ascii,      vecs[r].ascii);
      chk($sformatf("row%0d_held", r),   key_held,       vecs[r].held);
      chk($sformatf("row%0d_cnt", r),    press_count,    vecs[r].cnt);
      chk($sformatf("row%0d_cnt_nr", r), press_count_nr, vecs[r].cnt_nr);
      chk($sformatf("row%0d_makes", r),  n_mk,           vecs[r].mk);
      chk($sformatf("row%0d_breaks", r), n_bk,           vecs[r].bk);
    end

    // Counter wrap: 256 alternating distinct makes
    reset_async();
    for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    wait_idle(1000);
    chk("wrap_count",    press_count,    0);
    chk("wrap_count_nr", press_count_nr, 0);
    chk("wrap_code",     key_code,       8'h32);

    // Overflow sets the sticky flag; decoding carries on
    fifo_overflow = 1'b1; m_err = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    repeat (5) tick();
    push(8'h16);
    wait_idle(50);
    chk("ovf_sticky", err_sticky, 1);
    chk("ovf_code",   key_code,   8'h16);
    chk("ovf_ascii",  key_ascii,  8'h31);

    // Reset with E0 F0 pending: the following 1C is a plain make
    reset_async();
    push(8'h1C);
    wait_idle(50);
    push(8'hE0); push(8'hF0);
    wait_idle(50);
    reset_async();
    n_mk = 0;
    push(8'h1C);
    wait_idle(50);
    chk("midrst_ext",   key_ext,     0);
    chk("midrst_held",  key_held,    1);
    chk("midrst_cnt",   press_count, 1);
    chk("midrst_makes", n_mk,        1);

    // Randomised byte stream against the reference model
    reset_async();
    for (int i = 0; i < 400; i++) begin
      int unsigned rv;
      rv = $urandom_range(0, 99);
      if (rv < 10)      push(8'hE0);
      else if (rv < 28) push(8'hF0);
      else if (rv < 31) push(8'hFF);
      else if (rv < 33) push(8'h00);
      else              push(pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 4)) tick();
    end
    wait_idle(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumer stage placed directly downstream of the PS/2 receive FIFO (ps2_keyboard).
- Pops raw bytes through the FIFO's ready/nextdata_n handshake and parses Set-2 make/break/extended sequences (E0, F0 prefixes).
- Tracks the currently held key, converts it to ASCII and counts distinct key presses.
- Emits single-cycle make/break event pulses for display and control logic.

Parameters:
- CNT_W, 8: width of the press counter. Wraps modulo 2^CNT_W.
- IGNORE_REPEAT, 1: 1 = typematic repeats of the held key are neither counted nor pulsed. 0 = each repeat counts as a new make.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- fifo_data  in  8  byte at the head of the PS/2 FIFO.
- fifo_ready  in  1  FIFO non-empty.
- fifo_overflow  in  1  FIFO overflow flag.
- nextdata_n  out  1  active-low pop strobe to the FIFO. Registered; exactly one cycle low per byte.
- key_code  out  8  scancode of the last make.
- key_ext  out  1  last make was E0-prefixed.
- key_ascii  out  8  ASCII of key_code. 0x00 if key_ext=1 or the code is unmapped.
- key_held  out  1  a key is currently down.
- make_pulse  out  1  one-cycle pulse on an accepted make.
- break_pulse  out  1  one-cycle pulse on the release of the held key.
- press_count  out  CNT_W  number of accepted makes.
- err_sticky  out  1  overflow seen since reset.

Behaviour:
- Reset (async, clrn=0): state=S_IDLE, nextdata_n=1, all other outputs 0, pending flags ext_pend=brk_pend=0. Reset mid-sequence discards any partial prefix.
- FSM states: S_IDLE, S_POP, S_GAP.
  - S_IDLE: on fifo_ready=1, latch fifo_data into byte_r, drive nextdata_n=0 next cycle, go to S_POP. Otherwise stay.
  - S_POP: nextdata_n=0 for exactly this cycle; byte_r is parsed on this cycle's closing edge; go to S_GAP.
  - S_GAP: nextdata_n=1. One settle cycle so the FIFO's registered ready reflects the pop; go to S_IDLE.
  - Throughput: one byte per 3 cycles. Never pops while fifo_ready=0.
- Parse rules, applied once per byte at the end of S_POP:
  - 0xE0: ext_pend=1.
  - 0xF0: brk_pend=1.
  - 0x00 or 0xFF (keyboard error): clear both pending flags; nothing else changes.
  - Other byte with brk_pend=1: if key_held=1 and byte==key_code and ext_pend==key_ext, then key_held=0 and break_pulse=1. Otherwise (release of a non-held key) no output change. Clear both pending flags.
  - Other byte with brk_pend=0:
    - If key_held=1, byte==key_code, ext_pend==key_ext and IGNORE_REPEAT=1: repeat, no change.
    - Otherwise accept the make: key_code=byte, key_ext=ext_pend, key_ascii=lookup, key_held=1, make_pulse=1, press_count+1 (wraps max→0).
    - Clear both pending flags.
- All event outputs update on the same edge: one cycle after the S_POP cycle is entered, which is two edges after fifo_ready is sampled in S_IDLE.
- make_pulse and break_pulse are never high together. They are high for exactly one cycle.
- A new make while a different key is held replaces the held key (last-key-wins) and counts.
- err_sticky is set on any cycle with fifo_overflow=1. It is cleared only by reset. Decoding continues regardless.

Decomposition:
- Shared package ps2_pkg holds: scancode constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF; the state encoding typedef (S_IDLE/S_POP/S_GAP).
- Sub-module scancode_to_ascii: purely combinational Set-2 → ASCII ROM (8-bit in, 8-bit out).
  - Letters map to lowercase; digits and space are mapped; Enter=0x0D; unmapped codes give 0x00.
  - Its output is registered by the parent into key_ascii.

Test Plan:
- Make/break 'a': FIFO bytes 1C, F0, 1C. Expect one make_pulse with key_code=0x1C, key_ascii=0x61, key_held=1, press_count=1. Then one break_pulse, key_held=0. Three nextdata_n low pulses, each 1 cycle, separated by ≥2 cycles high.
- Typematic: 1C, 1C, 1C, F0, 1C with IGNORE_REPEAT=1. Expect press_count=1 and a single make_pulse. With IGNORE_REPEAT=0, expect press_count=3.
- Extended: E0, 75, E0, F0, 75. Expect key_code=0x75, key_ext=1, key_ascii=0x00, then break_pulse. A plain 75 break while ext is held gives no break_pulse.
- Overlap and ASCII spot check:
  - Sequence 16, 29, F0, 16: expect key_code 0x16 ('1', ascii 0x31), then 0x29 (ascii 0x20); press_count=2. The break of 16 does not clear key_held.
  - Send 5A: expect ascii 0x0D.
- Counter wrap and errors:
  - With CNT_W=8 issue 256 distinct makes: press_count returns to 0.
  - Byte FF after F0: pending flags clear; the following 1C counts as a make.
  - Pulse fifo_overflow: err_sticky=1 and stays 1.
- Reset mid-sequence: feed E0, F0, assert clrn=0 asynchronously between clock edges. All outputs go 0 immediately and nextdata_n=1. After release, feed 1C: a plain make with key_ext=0.
